// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin / fixed-priority stream multiplexer.
//   clog2      : constant ceiling-log2 used to size channel-index ports
//   mode_t     : arbitration mode encoding carried on the 1-bit mode input
package stream_mux_rr_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = int'(i) + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Combinational arbiter for stream_mux_rr.
//   req   : per-channel request (in_valid)
//   ptr   : first channel searched in round-robin mode
//   fixed : 1 = search from channel 0 (fixed priority, lowest index wins)
//   gnt   : one-hot grant, or zero when no request is present
module rr_pick
  import stream_mux_rr_pkg::*;
#(
  parameter int N = 4,
  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  input  logic          fixed,
  output logic [N-1:0]  gnt
);

  int   start;
  int   idx;
  logic found;

  // Scan N positions starting at start, wrapping modulo N; the first
  // requester seen wins. Fixed priority is just a scan from 0.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    start = fixed ? 0 : int'(ptr);
    if (start >= N) begin
      start = 0;
    end
    for (int unsigned k = 0; k < N; k++) begin
      idx = start + int'(k);
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel, W-bit valid/ready stream multiplexer with an internal arbiter
// (round-robin or fixed priority) and one registered output stage.
//   clk, rst  : clock, synchronous active-high reset
//   mode      : 0 = round-robin, 1 = fixed priority (lowest index wins)
//   in_data   : channel i at bits [i*W +: W]
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, combinational, at most one bit high
//   out_data  : registered data of the accepted beat
//   out_chan  : index of the channel that supplied out_data
//   out_valid : registered valid
//   out_ready : consumer ready
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic          load;
  logic          take;
  logic [N-1:0]  gnt;
  logic [CW-1:0] rr_ptr;
  logic [CW-1:0] nxt_ptr;
  logic [CW-1:0] sel_chan;
  logic [W-1:0]  sel_data;

  // The output register can accept when empty or when its beat leaves this edge.
  assign load = ~out_valid | out_ready;

  rr_pick #(.N(N)) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .fixed (mode == MODE_FIXED),
    .gnt   (gnt)
  );

  assign in_ready = (rst || !load) ? '0 : gnt;
  assign take     = |in_ready;

  // AND-OR select over the one-hot grant; the index encode rides the same loop.
  always_comb begin
    sel_data = '0;
    sel_chan = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*W +: W] & {W{gnt[i]}});
      if (gnt[i]) begin
        sel_chan = sel_chan | CW'(i);
      end
    end
  end

  // Explicit wrap so non-power-of-two N never points past the last channel.
  always_comb begin
    if (sel_chan == CW'(N - 1)) begin
      nxt_ptr = '0;
    end else begin
      nxt_ptr = sel_chan + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= sel_chan;
        if (mode == MODE_RR) begin
          rr_ptr <= nxt_ptr;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with a valid/ready handshake on every port and one registered output stage. It generalises the fixed 2:1 and 4:1 select muxes: instead of an external select, an internal arbiter picks the channel, in round-robin or fixed-priority mode. It sits wherever several producers share one consumer, such as a shared bus port or a shared FIFO write side.

## Interface
- N, 4, number of input channels (N ≥ 2; need not be a power of two)
- W, 8, data width per channel
- CW, derived = max(1, clog2(N)), channel-index width; not overridable
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (combinational)
- out_data  output  W  registered data
- out_chan  output  CW  index of the channel that supplied out_data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

## Operation
- Reset values: out_valid=0, out_data=0, out_chan=0, rr_ptr=0. rr_ptr is the first channel searched in round-robin mode.
- Load condition: load = ~out_valid | out_ready.
- Grant is combinational and one-hot (or zero):
  - mode=0: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo N.
  - mode=1: lowest i with in_valid[i]=1.
- in_ready[i] = grant[i] & load. At most one in_ready bit is high per cycle. in_ready never depends on out_valid of a stalled beat beyond this formula.
- Transfer on input i occurs when in_valid[i] & in_ready[i]. On that edge:
  - out_data ← channel i data
  - out_chan ← i
  - out_valid ← 1
- If load=1 and no channel is valid: out_valid ← 0. out_data and out_chan hold their values; they are don't-care while out_valid=0.
- If load=0 (out_valid=1 and out_ready=0): the output register holds, and no input is accepted.
- rr_ptr update: on a transfer while mode=0, rr_ptr ← (i+1) mod N, wrapping from N-1 to 0. In mode=1, rr_ptr holds.
- Mode changes take effect on the next grant evaluation. The beat already held in the output register is unaffected.
- Fairness in mode=0: with all N channels valid continuously and out_ready=1, each channel is granted exactly once every N cycles.
- Producers must hold in_data and in_valid stable until accepted. The block does not check this.

## Timing
- Latency is 1 cycle from the input-accept edge to out_valid. Throughput is 1 beat/cycle when out_ready stays high.
- Simultaneous events: an output transfer (out_valid & out_ready) and a new input accept on the same edge are a single load. There is no bubble.
- Reset mid-operation: a beat held in the output register is dropped. Outputs return to their reset values on the edge where rst=1. in_ready is 0 while rst=1.
- There is no combinational path from in_valid or in_data to out_valid or out_data. The only combinational path to in_ready comes from out_ready, in_valid, mode, and rr_ptr.

## Structure
- The shared package holds:
  - the clog2 constant function (used for CW)
  - mode encodings MODE_RR=1'b0 and MODE_FIXED=1'b1
- One sub-module, rr_pick: combinational, parameter N, inputs req[N], ptr[CW] and fixed, output gnt[N] (one-hot or zero). fixed=1 forces ptr to 0.
- The top level contains the load logic, the output register, rr_ptr, and the data select (an AND-OR over the one-hot grant).

## Test plan
1. Reset: hold rst=1 with every in_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0. After release, channel 0 is accepted first.
2. Round-robin, N=4: all valid, out_ready=1 → out_chan sequence 0,1,2,3,0,1…. Each in_ready pulse lasts one cycle. out_data matches the per-channel values (e.g. 8'hA0+i).
3. Fixed priority: mode=1, channels 1 and 3 valid → only channel 1 is accepted. Drop in_valid[1] → channel 3 is accepted on the next cycle. rr_ptr is unchanged.
4. Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data and out_chan stable, all in_ready=0. Raise out_ready → the held beat transfers and the next beat loads on the same edge.
5. Wrap and sparse traffic in round-robin: rr_ptr=3, only channel 0 valid → channel 0 granted and rr_ptr becomes 1. Then channels 0 and 2 valid → channel 2 is granted before channel 0.
6. Reset mid-stream: assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, rr_ptr=0. The held beat never appears at the output.
